// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline boundary: captures ALU result/flags with control bits, resolves branches,
// and feeds MEM through a 2-entry skid buffer. Optional perf counters: define EX_MEM_PERF_CNT_EN.
module ex_mem_stage #(
  parameter int DW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_result,
  input  logic           in_zero,
  input  logic           in_lt,
  input  logic           in_gt,
  input  logic [2:0]     in_br_type,
  input  logic [DW-1:0]  in_br_target,
  input  logic [DW-1:0]  in_store_data,
  input  logic [RAW-1:0] in_rd,
  input  logic [2:0]     in_ctl,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_result,
  output logic [DW-1:0]  out_store_data,
  output logic [DW-1:0]  out_br_target,
  output logic [RAW-1:0] out_rd,
  output logic [2:0]     out_ctl,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [31:0]    perf_br_taken,
  output logic [31:0]    perf_stall,
`endif
  output logic           out_br_taken
);

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_BGT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;

  typedef struct packed {
    logic [DW-1:0]  result;
    logic [DW-1:0]  store_data;
    logic [DW-1:0]  br_target;
    logic [RAW-1:0] rd;
    logic [2:0]     ctl;
    logic           br_taken;
  } ent_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_nxt;
  ent_t   head, skid, in_ent;
  logic   vld_q, rdy_q;
  logic   acc, deq;
  logic   head_ld, head_from_skid, skid_ld;
  logic   br_dec;

  // Zero dominates: an equal compare is never treated as LT or GT.
  always_comb begin
    br_dec = 1'b0;
    case (in_br_type)
      BR_BEQ:  br_dec = in_zero;
      BR_BNE:  br_dec = ~in_zero;
      BR_BLT:  br_dec = in_lt & ~in_zero;
      BR_BGT:  br_dec = in_gt & ~in_zero;
      BR_BGE:  br_dec = in_gt | in_zero;
      BR_NONE: br_dec = 1'b0;
      default: br_dec = 1'b0;
    endcase
  end

  always_comb begin
    in_ent.result     = in_result;
    in_ent.store_data = in_store_data;
    in_ent.br_target  = in_br_target;
    in_ent.rd         = in_rd;
    in_ent.ctl        = in_ctl;
    in_ent.br_taken   = br_dec;
  end

  assign acc = in_valid & rdy_q;
  assign deq = vld_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          state_nxt = ONE;
          head_ld   = 1'b1;
        end
        ONE: begin
          if (acc && deq) begin
            head_ld = 1'b1;
          end else if (acc) begin
            state_nxt = FULL;
            skid_ld   = 1'b1;
          end else if (deq) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (deq) begin
          state_nxt      = ONE;
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs come straight from flops so in_ready never depends on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      vld_q <= (state_nxt != EMPTY);
      rdy_q <= (state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_ld) head <= head_from_skid ? skid : in_ent;
      if (skid_ld) skid <= in_ent;
    end
  end

  assign in_ready       = rdy_q;
  assign out_valid      = vld_q;
  assign out_result     = head.result;
  assign out_store_data = head.store_data;
  assign out_br_target  = head.br_target;
  assign out_rd         = head.rd;
  assign out_ctl        = head.ctl;
  assign out_br_taken   = head.br_taken;

`ifdef EX_MEM_PERF_CNT_EN
  // Counters survive flush; only reset clears them. Both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_taken <= '0;
      perf_stall    <= '0;
    end else begin
      if (deq && head.br_taken) perf_br_taken <= perf_br_taken + 32'd1;
      if (vld_q && !out_ready)  perf_stall    <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, branch resolution, skid ordering, flush, async reset.
module tb_ex_mem_stage;
  localparam int DW  = 32;
  localparam int RAW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW-1:0]  in_result = '0;
  logic           in_zero = 1'b0, in_lt = 1'b0, in_gt = 1'b0;
  logic [2:0]     in_br_type = 3'b000;
  logic [DW-1:0]  in_br_target = '0;
  logic [DW-1:0]  in_store_data = '0;
  logic [RAW-1:0] in_rd = '0;
  logic [2:0]     in_ctl = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_result, out_store_data, out_br_target;
  logic [RAW-1:0] out_rd;
  logic [2:0]     out_ctl;
  logic           out_br_taken;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0]    perf_br_taken, perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  ex_mem_stage #(.DW(DW), .RAW(RAW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_zero(in_zero), .in_lt(in_lt), .in_gt(in_gt),
    .in_br_type(in_br_type), .in_br_target(in_br_target),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_ctl(in_ctl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_br_target(out_br_target), .out_rd(out_rd), .out_ctl(out_ctl),
`ifdef EX_MEM_PERF_CNT_EN
    .perf_br_taken(perf_br_taken), .perf_stall(perf_stall),
`endif
    .out_br_taken(out_br_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {br_type, zero, lt, gt, expected taken}
  logic [6:0] br_tab [10];

  initial begin
    br_tab[0] = {3'b011, 1'b1, 1'b1, 1'b0, 1'b0}; // BLT with zero: equal is not LT
    br_tab[1] = {3'b101, 1'b1, 1'b1, 1'b0, 1'b1}; // BGE with zero
    br_tab[2] = {3'b001, 1'b1, 1'b0, 1'b0, 1'b1}; // BEQ taken
    br_tab[3] = {3'b001, 1'b0, 1'b1, 1'b0, 1'b0}; // BEQ not taken
    br_tab[4] = {3'b010, 1'b1, 1'b0, 1'b0, 1'b0}; // BNE not taken
    br_tab[5] = {3'b011, 1'b0, 1'b1, 1'b0, 1'b1}; // BLT taken
    br_tab[6] = {3'b100, 1'b1, 1'b0, 1'b1, 1'b0}; // BGT with zero
    br_tab[7] = {3'b100, 1'b0, 1'b0, 1'b1, 1'b1}; // BGT taken
    br_tab[8] = {3'b110, 1'b1, 1'b1, 1'b1, 1'b0}; // reserved
    br_tab[9] = {3'b000, 1'b1, 1'b0, 1'b1, 1'b0}; // none

    // async reset asserted between edges
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_result", 64'(out_result), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // single BNE entry, 1-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_result = 32'd5; in_zero = 1'b0; in_br_type = 3'b010;
    in_br_target = 32'h0000_1234; in_store_data = 32'hDEAD_BEEF; in_rd = 5'd7; in_ctl = 3'b100;
    tick();
    in_valid = 1'b0;
    chk("bne_valid", 64'(out_valid), 64'd1);
    chk("bne_result", 64'(out_result), 64'd5);
    chk("bne_taken", 64'(out_br_taken), 64'd1);
    chk("bne_target", 64'(out_br_target), 64'h1234);
    chk("bne_sdata", 64'(out_store_data), 64'hDEADBEEF);
    chk("bne_rd", 64'(out_rd), 64'd7);
    chk("bne_ctl", 64'(out_ctl), 64'd4);
    tick();
    chk("bne_drained", 64'(out_valid), 64'd0);

    // streaming branch table with out_ready held high
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_result = 32'(100 + i);
      {in_br_type, in_zero, in_lt, in_gt} = br_tab[i][6:1];
      tick();
      chk($sformatf("br%0d_taken", i), 64'(out_br_taken), 64'(br_tab[i][0]));
      chk($sformatf("br%0d_result", i), 64'(out_result), 64'(100 + i));
    end
    in_valid = 1'b0; in_br_type = 3'b000; in_zero = 1'b0; in_lt = 1'b0; in_gt = 1'b0;
    tick();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // fill skid buffer under backpressure, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'd1;
    tick();
    chk("skA_valid", 64'(out_valid), 64'd1);
    chk("skA_ready", 64'(in_ready), 64'd1);
    in_result = 32'd2;
    tick();
    chk("skB_ready", 64'(in_ready), 64'd0);
    chk("skB_head", 64'(out_result), 64'd1);
    in_result = 32'd3;
    tick();
    chk("sk_stall_head", 64'(out_result), 64'd1);
    chk("sk_stall_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("sk_drainB_result", 64'(out_result), 64'd2);
    chk("sk_drainB_valid", 64'(out_valid), 64'd1);
    chk("sk_drainB_ready", 64'(in_ready), 64'd1);
    tick();
    chk("sk_empty", 64'(out_valid), 64'd0);

    // flush while FULL with an entry offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'd10;
    tick();
    in_result = 32'd11;
    tick();
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_result = 32'd12;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("fl_dropped", 64'(out_valid), 64'd0);

    // async reset in the middle of a held entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'h55;
    tick();
    in_valid = 1'b0;
    chk("ar_loaded", 64'(out_result), 64'h55);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_result", 64'(out_result), 64'd0);
    chk("ar_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("ar_after", 64'(out_valid), 64'd0);

`ifdef EX_MEM_PERF_CNT_EN
    // 3 taken branches dequeued; 4 stall cycles
    out_ready = 1'b1;
    in_br_type = 3'b001; in_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick(); tick(); tick(); tick();
    out_ready = 1'b1;
    tick();
    in_br_type = 3'b000; in_zero = 1'b0;
    chk("perf_taken", 64'(perf_br_taken), 64'd3);
    chk("perf_stall", 64'(perf_stall), 64'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf_taken_flush", 64'(perf_br_taken), 64'd3);
    chk("perf_stall_flush", 64'(perf_stall), 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
